calendar_date_engine: RTL
=========================

Name: calendar_date_engine

Overview:
- Unified, parametrised day/month/year calendar counter. Successor to the separate year, month, day and days-in-month blocks.
- Advances on a one-cycle end-of-day pulse and generates month/year carry pulses.
- Supports per-field manual edit with day clamping, and a multi-cycle validated date load.
- Computes leap years division-free, using mod-100/mod-400 shadow counters.
- Sits between the time-of-day counter (EOD source) and the display/alarm logic.

Parameters:
- YEAR_W, 14, year field width.
- YEAR_MIN, 0, lowest year; the year field wraps to this value.
- YEAR_MAX, 9999, highest year; must satisfy YEAR_MAX < 2**YEAR_W.
- RST_YEAR, 2000, reset year.
- RST_MONTH, 1, reset month.
- RST_DAY, 1, reset day.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- eod  in  1  end-of-day strobe, one cycle wide
- sel  in  2  edit field select: 0=day, 1=month, 2=year, 3=none
- inc  in  1  manual increment of the selected field
- dec  in  1  manual decrement of the selected field
- load  in  1  date load request
- ld_year  in  YEAR_W  load year
- ld_month  in  4  load month
- ld_day  in  6  load day
- year  out  YEAR_W  current year
- month  out  4  current month, 1..12
- day  out  6  current day, 1..dim
- dim  out  6  days in the current month
- leap  out  1  current year is a leap year
- c_month  out  1  one-cycle pulse on month rollover
- c_year  out  1  one-cycle pulse on year rollover
- busy  out  1  load in progress
- load_err  out  1  one-cycle pulse when a load is rejected
- eod_ovr  out  1  sticky flag: an EOD was lost while busy; cleared by the next accepted load

Behaviour:
- Clock, reset and register timing:
  - One clock domain, clk; reset rst_n is asynchronous, active-low.
  - All outputs are registered.
  - Reset values: year=RST_YEAR, month=RST_MONTH, day=RST_DAY, c_month=c_year=busy=load_err=eod_ovr=0.
  - Shadow counters are reset to RST_YEAR%100 and (RST_YEAR/100)%4, computed at elaboration.
- Leap rule: leap = (m100!=0 && m100[1:0]==0) || (m100==0 && c4==0).
  - m100 = year mod 100; c4 = (year/100) mod 4.
  - Both shadows are updated in lockstep with every year change, and wrap with the year.
  - No runtime divide.
- dim: combinational from month and leap (31/30/28/29); the registered output follows with one cycle of latency.
- Priority per cycle, highest first: load start, eod, manual edit.
  - inc and dec both high: no operation.
  - Manual edit is ignored while busy.
- EOD, taking effect at the next edge:
  - If day < dim: day+1.
  - Otherwise day=1, month+1, and c_month pulses.
  - If month was also 12: month=1, year+1, and c_year pulses in the same cycle as c_month.
  - At YEAR_MAX the year wraps to YEAR_MIN and the shadows are reloaded from elaboration-time constants.
- Manual day edit:
  - Wraps 1..dim with no carry.
  - dec at day 1 goes to dim.
- Manual month edit:
  - Wraps 1..12 with no carry.
  - If day > new dim, day is clamped to the new dim in the same edge.
- Manual year edit:
  - Wraps between YEAR_MIN and YEAR_MAX.
  - 29/2 is clamped to 28/2 when the new year is not a leap year.
- Manual edits never pulse c_month or c_year.
- Load FSM, states IDLE, DIV, CHK:
  - IDLE: load=1 latches the ld_* inputs, sets busy=1 and goes to DIV.
  - DIV: each cycle subtracts 100 from a working copy and increments a quotient mod 4, until the working copy is < 100. Worst case 100 cycles for 9999.
  - CHK: validates year in [YEAR_MIN, YEAR_MAX], month 1..12 and day 1..dim(ld).
    - Valid: commits all fields and shadows, clears eod_ovr.
    - Invalid: pulses load_err; the date is unchanged.
    - Either way, busy clears and the FSM returns to IDLE.
  - load is ignored while busy.
- EOD while busy:
  - The first EOD is held in a pending bit and applied in the cycle after CHK, after the commit.
  - Further EODs set eod_ovr.
- Reset mid-load: the FSM returns to IDLE, the pending EOD is discarded and all values return to reset values.

Optional Feature:
- Macro CAL_DOW_EN.
- When defined:
  - Adds parameter RST_DOW (default 6, Saturday = 1/1/2000) and output dow[2:0] (0=Sun..6=Sat).
  - dow advances mod 7 on every applied EOD.
  - Manual edits and loads do not recompute dow.
  - Adds input ld_dow[2:0], committed with a valid load.
- When undefined: no dow logic and no dow ports.

Decomposition:
- Package cal_pkg holds:
  - month constants JAN..DEC;
  - the sel field encoding;
  - the FSM state typedef;
  - a function days_in_month(month, leap).
- One sub-module, cal_dim_lut: combinational month+leap to dim, instanced twice (current date and load-check path).

Test Plan:
- Reset with defaults -> 1/1/2000, leap=1, dim=31, busy=0. Then 59 EODs -> 29/2/2000; one more -> 1/3/2000 with a c_month pulse.
- Load 31/12/1899 then 60 EODs -> 1/3/1900, passing 28/2/1900 with no 29/2 (century non-leap). Load 28/2/2400, 1 EOD -> 29/2/2400.
- From 31/12/9999, 1 EOD -> 1/1/0 with c_month and c_year both high in the same cycle, leap=1.
- Set 31/1/2023, manual month inc -> 28/2/2023. Manual year dec from 29/2/2024 -> 28/2/2023. No carry pulses.
- Load 30/2/2024 -> load_err pulse after 22 busy cycles; date unchanged.
- Load 9999 with two EODs during busy -> first applied after commit, eod_ovr=1. A subsequent valid load clears eod_ovr.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared calendar constants, edit-select encoding, load FSM states and month-length helpers.
package cal_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    localparam logic [1:0] SEL_DAY   = 2'd0;
    localparam logic [1:0] SEL_MONTH = 2'd1;
    localparam logic [1:0] SEL_YEAR  = 2'd2;
    localparam logic [1:0] SEL_NONE  = 2'd3;

    typedef enum logic [1:0] {StIdle, StDiv, StChk} load_state_e;

    function automatic logic [5:0] days_in_month(input logic [3:0] month, input logic leap);
        case (month)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: days_in_month = 6'd31;
            APR, JUN, SEP, NOV:                days_in_month = 6'd30;
            FEB:                               days_in_month = leap ? 6'd29 : 6'd28;
            default:                           days_in_month = 6'd31;
        endcase
    endfunction

    // m100 = year mod 100, c4 = (year / 100) mod 4
    function automatic logic is_leap(input logic [6:0] m100, input logic [1:0] c4);
        is_leap = (m100 != 7'd0 && m100[1:0] == 2'b00) || (m100 == 7'd0 && c4 == 2'd0);
    endfunction

endpackage

// File: rtl/cal_dim_lut.sv
// Combinational days-in-month lookup from month and leap flag.
module cal_dim_lut
    import cal_pkg::*;
(
    input  logic [3:0] month,
    input  logic       leap,
    output logic [5:0] dim
);

    assign dim = days_in_month(month, leap);

endmodule

// File: rtl/calendar_date_engine.sv
// Day/month/year calendar with EOD advance, manual edits and a validated multi-cycle load.
// Optional day-of-week tracking is enabled by defining CAL_DOW_EN.
module calendar_date_engine
    import cal_pkg::*;
#(
    parameter int unsigned YEAR_W    = 14,
    parameter int unsigned YEAR_MIN  = 0,
    parameter int unsigned YEAR_MAX  = 9999,
    parameter int unsigned RST_YEAR  = 2000,
    parameter int unsigned RST_MONTH = 1,
    parameter int unsigned RST_DAY   = 1
`ifdef CAL_DOW_EN
    ,
    parameter int unsigned RST_DOW   = 6
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              eod,
    input  logic [1:0]        sel,
    input  logic              inc,
    input  logic              dec,
    input  logic              load,
    input  logic [YEAR_W-1:0] ld_year,
    input  logic [3:0]        ld_month,
    input  logic [5:0]        ld_day,
    output logic [YEAR_W-1:0] year,
    output logic [3:0]        month,
    output logic [5:0]        day,
    output logic [5:0]        dim,
    output logic              leap,
    output logic              c_month,
    output logic              c_year,
    output logic              busy,
    output logic              load_err,
    output logic              eod_ovr
`ifdef CAL_DOW_EN
    ,
    input  logic [2:0]        ld_dow,
    output logic [2:0]        dow
`endif
);

    localparam logic [YEAR_W-1:0] YMIN     = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YMAX     = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] HUNDRED  = YEAR_W'(100);
    localparam logic [6:0]        RST_M100 = 7'(RST_YEAR % 100);
    localparam logic [1:0]        RST_C4   = 2'((RST_YEAR / 100) % 4);
    localparam logic [6:0]        MIN_M100 = 7'(YEAR_MIN % 100);
    localparam logic [1:0]        MIN_C4   = 2'((YEAR_MIN / 100) % 4);
    localparam logic [6:0]        MAX_M100 = 7'(YEAR_MAX % 100);
    localparam logic [1:0]        MAX_C4   = 2'((YEAR_MAX / 100) % 4);
    localparam logic              RST_LEAP = is_leap(RST_M100, RST_C4);
    localparam logic [5:0]        RST_DIM  = days_in_month(4'(RST_MONTH), RST_LEAP);
    localparam logic signed [YEAR_W:0] YMIN_S = (YEAR_W+1)'(YEAR_MIN);

    load_state_e       state_q, state_d;
    logic [YEAR_W-1:0] year_q, year_d, ld_year_q, ld_year_d, work_q, work_d;
    logic [3:0]        month_q, month_d, ld_month_q, ld_month_d;
    logic [5:0]        day_q, day_d, ld_day_q, ld_day_d, dim_q;
    logic [6:0]        m100_q, m100_d;
    logic [1:0]        c4_q, c4_d, quot_q, quot_d;
    logic              leap_q, c_month_q, c_month_d, c_year_q, c_year_d, busy_q;
    logic              load_err_q, load_err_d, eod_ovr_q, eod_ovr_d;
    logic              ovr_cur_q, ovr_cur_d, pend_q, pend_d;
    logic              apply_eod, edit_ok, commit, load_start;
    logic              leap_cur, leap_ld, ld_ok;
    logic [5:0]        dim_cur, dim_ld, dim_new;

    assign leap_cur = is_leap(m100_q, c4_q);
    // In StChk the working copy is below 100, so its low bits are the load year's mod-100.
    assign leap_ld  = is_leap(work_q[6:0], quot_q);

    cal_dim_lut u_dim_cur (
        .month (month_q),
        .leap  (leap_cur),
        .dim   (dim_cur)
    );

    cal_dim_lut u_dim_ld (
        .month (ld_month_q),
        .leap  (leap_ld),
        .dim   (dim_ld)
    );

    assign ld_ok = ($signed({1'b0, ld_year_q}) >= YMIN_S) && (ld_year_q <= YMAX) &&
                   (ld_month_q >= JAN) && (ld_month_q <= DEC) &&
                   (ld_day_q != 6'd0) && (ld_day_q <= dim_ld);

    always_comb begin
        state_d    = state_q;
        year_d     = year_q;
        month_d    = month_q;
        day_d      = day_q;
        m100_d     = m100_q;
        c4_d       = c4_q;
        ld_year_d  = ld_year_q;
        ld_month_d = ld_month_q;
        ld_day_d   = ld_day_q;
        work_d     = work_q;
        quot_d     = quot_q;
        c_month_d  = 1'b0;
        c_year_d   = 1'b0;
        load_err_d = 1'b0;
        eod_ovr_d  = eod_ovr_q;
        ovr_cur_d  = ovr_cur_q;
        pend_d     = pend_q;
        apply_eod  = 1'b0;
        edit_ok    = 1'b0;
        commit     = 1'b0;
        load_start = 1'b0;
        dim_new    = dim_cur;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    load_start = 1'b1;
                    ld_year_d  = ld_year;
                    ld_month_d = ld_month;
                    ld_day_d   = ld_day;
                    work_d     = ld_year;
                    quot_d     = 2'd0;
                    ovr_cur_d  = 1'b0;
                    state_d    = StDiv;
                    if (eod || pend_q) pend_d = 1'b1;
                end else if (eod || pend_q) begin
                    apply_eod = 1'b1;
                    pend_d    = 1'b0;
                end else begin
                    edit_ok = 1'b1;
                end
                // A live EOD colliding with a still-pending one loses one day.
                if (eod && pend_q) eod_ovr_d = 1'b1;
            end
            StDiv: begin
                if (work_q >= HUNDRED) begin
                    work_d = work_q - HUNDRED;
                    quot_d = quot_q + 2'd1;
                end else begin
                    state_d = StChk;
                end
            end
            StChk: begin
                state_d = StIdle;
                if (ld_ok) begin
                    commit    = 1'b1;
                    year_d    = ld_year_q;
                    month_d   = ld_month_q;
                    day_d     = ld_day_q;
                    m100_d    = work_q[6:0];
                    c4_d      = quot_q;
                    // Overruns from before this load are cleared; ones during it survive.
                    eod_ovr_d = ovr_cur_q;
                end else begin
                    load_err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && eod) begin
            if (!pend_q) begin
                pend_d = 1'b1;
            end else begin
                eod_ovr_d = 1'b1;
                ovr_cur_d = 1'b1;
            end
        end

        if (apply_eod) begin
            if (day_q < dim_cur) begin
                day_d = day_q + 6'd1;
            end else begin
                day_d     = 6'd1;
                c_month_d = 1'b1;
                if (month_q == DEC) begin
                    month_d  = JAN;
                    c_year_d = 1'b1;
                    if (year_q == YMAX) begin
                        year_d = YMIN;
                        m100_d = MIN_M100;
                        c4_d   = MIN_C4;
                    end else begin
                        year_d = year_q + YEAR_W'(1);
                        if (m100_q == 7'd99) begin
                            m100_d = 7'd0;
                            c4_d   = c4_q + 2'd1;
                        end else begin
                            m100_d = m100_q + 7'd1;
                        end
                    end
                end else begin
                    month_d = month_q + 4'd1;
                end
            end
        end else if (edit_ok && (inc != dec)) begin
            case (sel)
                SEL_DAY: begin
                    if (inc) day_d = (day_q >= dim_cur) ? 6'd1 : day_q + 6'd1;
                    else     day_d = (day_q <= 6'd1) ? dim_cur : day_q - 6'd1;
                end
                SEL_MONTH: begin
                    if (inc) month_d = (month_q == DEC) ? JAN : month_q + 4'd1;
                    else     month_d = (month_q == JAN) ? DEC : month_q - 4'd1;
                    dim_new = days_in_month(month_d, leap_cur);
                    if (day_q > dim_new) day_d = dim_new;
                end
                SEL_YEAR: begin
                    if (inc) begin
                        if (year_q == YMAX) begin
                            year_d = YMIN;
                            m100_d = MIN_M100;
                            c4_d   = MIN_C4;
                        end else begin
                            year_d = year_q + YEAR_W'(1);
                            if (m100_q == 7'd99) begin
                                m100_d = 7'd0;
                                c4_d   = c4_q + 2'd1;
                            end else begin
                                m100_d = m100_q + 7'd1;
                            end
                        end
                    end else begin
                        if (year_q == YMIN) begin
                            year_d = YMAX;
                            m100_d = MAX_M100;
                            c4_d   = MAX_C4;
                        end else begin
                            year_d = year_q - YEAR_W'(1);
                            if (m100_q == 7'd0) begin
                                m100_d = 7'd99;
                                c4_d   = c4_q - 2'd1;
                            end else begin
                                m100_d = m100_q - 7'd1;
                            end
                        end
                    end
                    if (month_q == FEB && day_q == 6'd29 && !is_leap(m100_d, c4_d)) begin
                        day_d = 6'd28;
                    end
                end
                SEL_NONE: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            year_q     <= YEAR_W'(RST_YEAR);
            month_q    <= 4'(RST_MONTH);
            day_q      <= 6'(RST_DAY);
            m100_q     <= RST_M100;
            c4_q       <= RST_C4;
            leap_q     <= RST_LEAP;
            dim_q      <= RST_DIM;
            ld_year_q  <= '0;
            ld_month_q <= '0;
            ld_day_q   <= '0;
            work_q     <= '0;
            quot_q     <= '0;
            c_month_q  <= 1'b0;
            c_year_q   <= 1'b0;
            busy_q     <= 1'b0;
            load_err_q <= 1'b0;
            eod_ovr_q  <= 1'b0;
            ovr_cur_q  <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            year_q     <= year_d;
            month_q    <= month_d;
            day_q      <= day_d;
            m100_q     <= m100_d;
            c4_q       <= c4_d;
            leap_q     <= is_leap(m100_d, c4_d);
            dim_q      <= dim_cur;
            ld_year_q  <= ld_year_d;
            ld_month_q <= ld_month_d;
            ld_day_q   <= ld_day_d;
            work_q     <= work_d;
            quot_q     <= quot_d;
            c_month_q  <= c_month_d;
            c_year_q   <= c_year_d;
            busy_q     <= (state_d != StIdle);
            load_err_q <= load_err_d;
            eod_ovr_q  <= eod_ovr_d;
            ovr_cur_q  <= ovr_cur_d;
            pend_q     <= pend_d;
        end
    end

    assign year     = year_q;
    assign month    = month_q;
    assign day      = day_q;
    assign dim      = dim_q;
    assign leap     = leap_q;
    assign c_month  = c_month_q;
    assign c_year   = c_year_q;
    assign busy     = busy_q;
    assign load_err = load_err_q;
    assign eod_ovr  = eod_ovr_q;

`ifdef CAL_DOW_EN
    logic [2:0] dow_q, ld_dow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dow_q    <= 3'(RST_DOW);
            ld_dow_q <= '0;
        end else begin
            if (load_start) ld_dow_q <= ld_dow;
            if (apply_eod) begin
                dow_q <= (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
            end else if (commit) begin
                dow_q <= ld_dow_q;
            end
        end
    end

    assign dow = dow_q;
`else
    logic unused_flags;
    assign unused_flags = ^{commit, load_start};
`endif

endmodule
